// File: rtl/fe_fetch_predict_pkg.sv
// Shared widths, reset constants and latch/AGEX bundle layouts for the fetch stage.
package fe_fetch_predict_pkg;

  localparam int DBITS          = 32;
  localparam int PHT_IDX_BITS   = 10;
  localparam int GHR_BITS       = 10;
  localparam int BTB_ENTRIES    = 16;
  localparam int BTB_IDX_BITS   = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_BITS   = DBITS - BTB_IDX_BITS - 2;
  localparam int PHT_ENTRIES    = 1 << PHT_IDX_BITS;
  localparam int FE_LATCH_WIDTH = 171;
  localparam int AGEX_FE_WIDTH  = 79;

  localparam logic [DBITS-1:0] START_PC    = 32'h0;
  localparam logic [1:0]       PHT_WEAK_NT = 2'b01;

  // First member is the MSB of the flat bus.
  typedef struct packed {
    logic                    valid;
    logic [DBITS-1:0]        inst;
    logic [DBITS-1:0]        pc;
    logic [DBITS-1:0]        pcplus;
    logic [DBITS-1:0]        inst_count;
    logic [PHT_IDX_BITS-1:0] pht_index;
    logic [DBITS-1:0]        pred_pc;
  } fe_latch_t;

  typedef struct packed {
    logic                    br_mispred;
    logic [DBITS-1:0]        br_target;
    logic                    res_valid;
    logic                    res_is_cond;
    logic                    res_is_jmp;
    logic                    res_taken;
    logic [DBITS-1:0]        res_pc;
    logic [PHT_IDX_BITS-1:0] res_pht_index;
  } agex_fe_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/fe_fetch_predict_gshare.sv
// Gshare PHT + global history + direct-mapped BTB: combinational lookup, registered training.
// Only compiled when FE_BPRED_EN is defined.
`ifdef FE_BPRED_EN
module fe_fetch_predict_gshare
  import fe_fetch_predict_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        pc_i,
  output logic                    pred_taken_o,
  output logic [DBITS-1:0]        pred_target_o,
  output logic [PHT_IDX_BITS-1:0] pht_idx_o,
  input  logic                    train_valid_i,
  input  logic                    train_is_cond_i,
  input  logic                    train_is_jmp_i,
  input  logic                    train_taken_i,
  input  logic [DBITS-1:0]        train_pc_i,
  input  logic [DBITS-1:0]        train_target_i,
  input  logic [PHT_IDX_BITS-1:0] train_idx_i
);

  logic [1:0]              pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0]     ghr_q, ghr_d;
  logic                    btb_valid_q  [BTB_ENTRIES];
  logic [BTB_TAG_BITS-1:0] btb_tag_q    [BTB_ENTRIES];
  logic                    btb_jmp_q    [BTB_ENTRIES];
  logic [DBITS-1:0]        btb_target_q [BTB_ENTRIES];

  logic [BTB_IDX_BITS-1:0] look_ent, train_ent;
  logic                    look_hit;
  logic                    pht_we, btb_we;
  logic [1:0]              pht_upd_d;
  logic                    unused_lsbs;

  assign unused_lsbs = ^{pc_i[1:0], train_pc_i[1:0]};

  assign pht_idx_o     = pc_i[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
  assign look_ent      = pc_i[BTB_IDX_BITS+1:2];
  assign look_hit      = btb_valid_q[look_ent] &&
                         (btb_tag_q[look_ent] == pc_i[DBITS-1:BTB_IDX_BITS+2]);
  assign pred_taken_o  = look_hit && (btb_jmp_q[look_ent] || pht_q[pht_idx_o][1]);
  assign pred_target_o = btb_target_q[look_ent];

  assign train_ent = train_pc_i[BTB_IDX_BITS+1:2];
  assign pht_we    = train_valid_i && train_is_cond_i;
  assign btb_we    = train_valid_i && train_taken_i;
  assign pht_upd_d = sat_update(pht_q[train_idx_i], train_taken_i);
  // History is non-speculative: it only moves on resolved conditional branches.
  assign ghr_d     = pht_we ? {ghr_q[GHR_BITS-2:0], train_taken_i} : ghr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_WEAK_NT;
      ghr_q <= '0;
    end else begin
      if (pht_we) pht_q[train_idx_i] <= pht_upd_d;
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid_q[train_ent]  <= 1'b1;
      btb_tag_q[train_ent]    <= train_pc_i[DBITS-1:BTB_IDX_BITS+2];
      btb_jmp_q[train_ent]    <= train_is_jmp_i;
      btb_target_q[train_ent] <= train_target_i;
    end
  end

endmodule
`endif

// File: rtl/fe_fetch_predict.sv
// RV32 fetch stage: PC, instruction count, FE latch and stall/mispredict priority.
// FE_BPRED_EN enables the gshare/BTB predictor; otherwise next PC is always PC+4.
module fe_fetch_predict
  import fe_fetch_predict_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  output logic [DBITS-1:0]          imem_addr,
  input  logic [DBITS-1:0]          imem_rdata,
  input  logic                      from_DE_to_FE,
  input  logic [AGEX_FE_WIDTH-1:0]  from_AGEX_to_FE,
  output logic [FE_LATCH_WIDTH-1:0] FE_latch_out
);

  agex_fe_t                agex;
  fe_latch_t               latch_q, latch_d;
  logic [DBITS-1:0]        pc_q, pc_d;
  logic [DBITS-1:0]        cnt_q, cnt_d;
  logic [DBITS-1:0]        pcplus;
  logic [DBITS-1:0]        pred_pc;
  logic [PHT_IDX_BITS-1:0] pht_idx;

  assign agex         = agex_fe_t'(from_AGEX_to_FE);
  assign pcplus       = pc_q + 32'd4;
  assign imem_addr    = pc_q;
  assign FE_latch_out = latch_q;

`ifdef FE_BPRED_EN
  logic             pred_taken;
  logic [DBITS-1:0] pred_target;

  fe_fetch_predict_gshare u_gshare (
    .clk            (clk),
    .reset          (reset),
    .pc_i           (pc_q),
    .pred_taken_o   (pred_taken),
    .pred_target_o  (pred_target),
    .pht_idx_o      (pht_idx),
    .train_valid_i  (agex.res_valid),
    .train_is_cond_i(agex.res_is_cond),
    .train_is_jmp_i (agex.res_is_jmp),
    .train_taken_i  (agex.res_taken),
    .train_pc_i     (agex.res_pc),
    .train_target_i (agex.br_target),
    .train_idx_i    (agex.res_pht_index)
  );

  assign pred_pc = pred_taken ? pred_target : pcplus;
`else
  logic unused_train;

  assign unused_train = ^{agex.res_valid, agex.res_is_cond, agex.res_is_jmp,
                          agex.res_taken, agex.res_pc, agex.res_pht_index};
  assign pred_pc      = pcplus;
  assign pht_idx      = '0;
`endif

  // Mispredict beats stall: decode stalls during a redirect, but the bubble must still go in.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    if (agex.br_mispred) begin
      pc_d    = agex.br_target;
      latch_d = '0;
    end else if (!from_DE_to_FE) begin
      latch_d = '{valid:      1'b1,
                  inst:       imem_rdata,
                  pc:         pc_q,
                  pcplus:     pcplus,
                  inst_count: cnt_q,
                  pht_index:  pht_idx,
                  pred_pc:    pred_pc};
      pc_d    = pred_pc;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= START_PC;
      cnt_q   <= '0;
      latch_q <= '0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

endmodule

// File: tb/tb_fe_fetch_predict.sv
// Directed bench for fe_fetch_predict; expectations follow FE_BPRED_EN when it is defined.
module tb_fe_fetch_predict;

  localparam logic [31:0] INST_XOR = 32'h1300_0013;
`ifdef FE_BPRED_EN
  localparam bit          BPRED    = 1'b1;
  localparam logic [9:0]  IDX_MASK = 10'h3FF;
`else
  localparam bit          BPRED    = 1'b0;
  localparam logic [9:0]  IDX_MASK = 10'h000;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         from_DE_to_FE;
  logic [78:0]  from_AGEX_to_FE;
  logic [170:0] FE_latch_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ INST_XOR;

  fe_fetch_predict dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .from_DE_to_FE  (from_DE_to_FE),
    .from_AGEX_to_FE(from_AGEX_to_FE),
    .FE_latch_out   (FE_latch_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_idx(input logic [31:0] pc, input logic [9:0] ghr);
    return (pc[11:2] ^ ghr) & IDX_MASK;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic agex(input logic mis, input logic [31:0] tgt, input logic rv, input logic cond,
                      input logic jmp, input logic tk, input logic [31:0] rpc, input logic [9:0] ridx);
    from_AGEX_to_FE = {mis, tgt, rv, cond, jmp, tk, rpc, ridx};
  endtask

  task automatic quiet();
    agex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0);
  endtask

  // Latch layout: valid[170] inst[169:138] pc[137:106] pcplus[105:74] cnt[73:42] idx[41:32] pred[31:0]
  task automatic chk_lat(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                         input logic [31:0] pred, input logic [9:0] idx);
    chk({tag, "_valid"},  32'(FE_latch_out[170]),     32'd1);
    chk({tag, "_inst"},   FE_latch_out[169:138],      pc ^ INST_XOR);
    chk({tag, "_pc"},     FE_latch_out[137:106],      pc);
    chk({tag, "_pcplus"}, FE_latch_out[105:74],       pc + 32'd4);
    chk({tag, "_cnt"},    FE_latch_out[73:42],        cnt);
    chk({tag, "_idx"},    32'(FE_latch_out[41:32]),   32'(idx));
    chk({tag, "_pred"},   FE_latch_out[31:0],         pred);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(FE_latch_out[170]),      32'd0);
    chk({tag, "_zero"},  32'(FE_latch_out != '0),     32'd0);
  endtask

  initial begin
    reset = 1'b1;
    from_DE_to_FE = 1'b0;
    quiet();
    tick();
    tick();
    chk_bubble("rst");
    chk("rst_pc", imem_addr, 32'h0);

    // Sequential fetch from reset
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_lat($sformatf("seq%0d", i), 32'(4 * i), 32'(i), 32'(4 * i + 4), exp_idx(32'(4 * i), 10'h0));
    end
    chk("seq_pc", imem_addr, 32'h14);

    // Decode stall freezes latch (PC 0x10) and fetch PC (0x14)
    from_DE_to_FE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_lat($sformatf("stall%0d", i), 32'h10, 32'd4, 32'h14, exp_idx(32'h10, 10'h0));
      chk($sformatf("stall%0d_fpc", i), imem_addr, 32'h14);
    end
    from_DE_to_FE = 1'b0;
    tick();
    chk_lat("unstall", 32'h14, 32'd5, 32'h18, exp_idx(32'h14, 10'h0));

    // Mispredict wins over a simultaneous stall
    from_DE_to_FE = 1'b1;
    agex(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0);
    tick();
    chk_bubble("mis");
    chk("mis_fpc", imem_addr, 32'h200);
    from_DE_to_FE = 1'b0;
    quiet();
    tick();
    chk_lat("mis_fetch", 32'h200, 32'd6, 32'h204, exp_idx(32'h200, 10'h0));

    // Cond branch at 0x40 taken twice into idx 0x13 (= 0x10 ^ GHR 2'b11 after training)
    from_DE_to_FE = 1'b1;
    agex(1'b0, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 10'h13);
    tick();
    tick();
    chk("train_fpc", imem_addr, 32'h204);
    agex(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0);
    tick();
    chk_bubble("t4_bub");
    quiet();
    from_DE_to_FE = 1'b0;
    tick();
    chk_lat("t4", 32'h40, 32'd7, BPRED ? 32'h80 : 32'h44, exp_idx(32'h40, 10'h3));
    chk("t4_fpc", imem_addr, BPRED ? 32'h80 : 32'h44);

    // Unconditional jump at 0x48 -> 0x100; PHT for 0x48 is still weak-NT
    from_DE_to_FE = 1'b1;
    agex(1'b0, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h48, 10'h0);
    tick();
    agex(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0);
    tick();
    quiet();
    from_DE_to_FE = 1'b0;
    tick();
    chk_lat("t5_jmp", 32'h48, 32'd8, BPRED ? 32'h100 : 32'h4C, exp_idx(32'h48, 10'h3));

    // 0x88 shares BTB entry 2 with 0x48 but has a different tag
    agex(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0);
    tick();
    chk_bubble("t5_bub");
    quiet();
    tick();
    chk_lat("t5_alias", 32'h88, 32'd9, 32'h8C, exp_idx(32'h88, 10'h3));

    // Reset beats mispredict, stall and training in the same cycle
    reset = 1'b1;
    from_DE_to_FE = 1'b1;
    agex(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 10'h10);
    tick();
    chk_bubble("rst2");
    chk("rst2_pc", imem_addr, 32'h0);
    reset = 1'b0;
    from_DE_to_FE = 1'b0;
    quiet();
    tick();
    chk_lat("rst2_fetch", 32'h0, 32'd0, 32'h4, exp_idx(32'h0, 10'h0));
    agex(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'h0);
    tick();
    quiet();
    tick();
    chk_lat("rst2_40", 32'h40, 32'd1, 32'h44, exp_idx(32'h40, 10'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
